key_onehot_capture: RTL and testbench

//  Upstream feeder for the 4-to-2 encoder. Takes four raw push-button inputs, synchronises
//  and debounces each one, and validates that exactly one key is pressed. It then drives a

---
 rtl/key_onehot_capture_pkg.sv | 18 +
 rtl/key_onehot_capture_if.sv | 16 +
 rtl/key_onehot_capture_debounce.sv | 54 +++++
 rtl/key_onehot_capture.sv | 105 ++++++++++
 tb/tb_key_onehot_capture.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/key_onehot_capture_pkg.sv
// key_pkg: shared key count, FSM state type and a small popcount helper
// used by the capture top and its interface.
package key_pkg;
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } state_e;

  function automatic logic [2:0] popcount(input logic [NUM_KEYS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/key_onehot_capture_if.sv
// key_onehot_capture_if: raw keys in, validated one-hot code out.
//  key_raw     raw asynchronous button levels (driven by master)
//  onehot      one-hot code of the held key, 0 when en=0
//  en          exactly one debounced key held
//  press_pulse one-cycle strobe when en rises
//  multi_err   high while a multi-key press is being rejected
interface key_onehot_capture_if;
  logic [key_pkg::NUM_KEYS-1:0] key_raw;
  logic [key_pkg::NUM_KEYS-1:0] onehot;
  logic                         en;
  logic                         press_pulse;
  logic                         multi_err;

  modport master (output key_raw, input onehot, en, press_pulse, multi_err);
  modport slave  (input key_raw, output onehot, en, press_pulse, multi_err);
endinterface

// File: rtl/key_onehot_capture_debounce.sv
// key_debounce: 2-FF synchroniser, polarity normalisation and counter-based
// debounce for a single key.
//  clk, rst   clock, async active-high reset
//  raw_i      raw button level
//  stable_o   debounced level, 1 = pressed
//  rise_o     stable_o went 0->1 on the previous edge
module key_debounce #(
  parameter int DB_CYCLES      = 1000,
  parameter int CNT_W          = 10,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);
  localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0);

  logic             s1_q, s2_q, stable_q, stable_d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pressed;

  // normalise after the synchroniser so pressed reads as 1
  assign pressed = s2_q ^ REL_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= REL_LVL;
      s2_q       <= REL_LVL;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= raw_i;
      s2_q       <= s1_q;
      stable_d_q <= stable_q;
      if (pressed != stable_q) begin
        // level must disagree for DB_CYCLES consecutive edges to be taken
        if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
          stable_q <= pressed;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~stable_d_q;
endmodule

// File: rtl/key_onehot_capture.sv
// key_onehot_capture: debounces four keys and publishes a clean one-hot code
// plus enable only while exactly one key is held. Multi-key presses park the
// block in ERROR until every key is released.
//  clk, rst  clock, async active-high reset
//  kif       slave side of key_onehot_capture_if (key_raw in, registered outputs)
module key_onehot_capture
  import key_pkg::*;
#(
  parameter int DB_CYCLES      = 1000,
  parameter int CNT_W          = 10,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input logic                  clk,
  input logic                  rst,
  key_onehot_capture_if.slave  kif
);
  logic [NUM_KEYS-1:0] stable, rise;
  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] onehot_q, onehot_d;
  logic                en_q, en_d, pulse_q, pulse_d, err_q, err_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
    key_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .CNT_W          (CNT_W),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (kif.key_raw[k]),
      .stable_o (stable[k]),
      .rise_o   (rise[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      en_q     <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      en_q     <= en_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    en_d     = en_q;
    pulse_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        // accept only a lone rise with no other key already down
        if (popcount(rise) == 3'd1 && stable == rise) begin
          state_d  = HOLD;
          onehot_d = rise;
          en_d     = 1'b1;
          pulse_d  = 1'b1;
        end else if (rise != '0 && popcount(stable) > 3'd1) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      HOLD: begin
        if (stable == onehot_q) begin
          state_d = HOLD;
        end else if (stable == '0) begin
          state_d  = IDLE;
          onehot_d = '0;
          en_d     = 1'b0;
        end else begin
          // any other key seen, even alongside a release, is a multi-press
          state_d  = ERROR;
          onehot_d = '0;
          en_d     = 1'b0;
          err_d    = 1'b1;
        end
      end
      ERROR: begin
        if (stable == '0) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        en_d     = 1'b0;
        err_d    = 1'b0;
      end
    endcase
  end

  assign kif.onehot      = onehot_q;
  assign kif.en          = en_q;
  assign kif.press_pulse = pulse_q;
  assign kif.multi_err   = err_q;
endmodule

// File: tb/tb_key_onehot_capture.sv
module tb_key_onehot_capture;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;
  logic saw_en, saw_pulse;

  key_onehot_capture_if kif ();

  key_onehot_capture #(.DB_CYCLES(DB), .CNT_W(3), .KEY_ACTIVE_LOW(1)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  // reference model: keys seen as sets of pressed bits, a held key index,
  // and a sliding window of synchronised samples per key
  logic [3:0] m_s1, m_s2, m_stab, m_stab_d;
  logic [3:0] m_hist [DB];
  int         held;
  logic       merr, mpulse;

  function automatic int pc(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_stab_d = '0;
    for (int j = 0; j < DB; j++) m_hist[j] = '0;
    held = -1; merr = 1'b0; mpulse = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rise, nstab;
    logic       flip;
    rise   = m_stab & ~m_stab_d;
    mpulse = 1'b0;
    if (merr) begin
      if (m_stab == 4'd0) merr = 1'b0;
    end else if (held < 0) begin
      if (pc(rise) == 1 && m_stab == rise) begin
        held = idx(rise); mpulse = 1'b1;
      end else if (rise != 4'd0 && pc(m_stab) > 1) begin
        merr = 1'b1;
      end
    end else if (m_stab != (4'b0001 << held)) begin
      if (m_stab != 4'd0) merr = 1'b1;
      held = -1;
    end
    for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_s2;
    nstab = m_stab;
    for (int k = 0; k < 4; k++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (m_hist[j][k] == m_stab[k]) flip = 1'b0;
      if (flip) nstab[k] = ~m_stab[k];
    end
    m_stab_d = m_stab;
    m_stab   = nstab;
    m_s2     = m_s1;
    m_s1     = ~kif.key_raw;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] e_oh;
    e_oh = (held >= 0) ? (4'b0001 << held) : 4'd0;
    chk("onehot", kif.onehot, e_oh);
    chk("en", {3'd0, kif.en}, {3'd0, held >= 0});
    chk("press_pulse", {3'd0, kif.press_pulse}, {3'd0, mpulse});
    chk("multi_err", {3'd0, kif.multi_err}, {3'd0, merr});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_model();
    if (kif.en) saw_en = 1'b1;
    if (kif.press_pulse) saw_pulse = 1'b1;
  endtask

  task automatic wait_en(input logic val, output int cnt);
    cnt = 0;
    while (kif.en !== val && cnt < 40) begin tick(); cnt++; end
  endtask

  task automatic wait_err(input logic val, output int cnt);
    cnt = 0;
    while (kif.multi_err !== val && cnt < 40) begin tick(); cnt++; end
  endtask

  task automatic settle();
    kif.key_raw = 4'b1111;
    repeat (DB + 6) tick();
  endtask

  initial begin
    kif.key_raw = 4'b1111;
    model_reset();
    saw_en = 1'b0; saw_pulse = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_onehot", kif.onehot, 4'd0);
    chk("rst_en", {3'd0, kif.en}, 4'd0);
    chk("rst_err", {3'd0, kif.multi_err}, 4'd0);
    rst = 1'b0;

    // 1: key 2 alone, en rises 7 cycles later with a single pulse
    kif.key_raw = 4'b1011;
    wait_en(1'b1, n);
    chk("t1_latency", 4'(n), 4'd7);
    chk("t1_onehot", kif.onehot, 4'b0100);
    chk("t1_pulse", {3'd0, kif.press_pulse}, 4'd1);
    tick();
    chk("t1_pulse_drop", {3'd0, kif.press_pulse}, 4'd0);
    settle();

    // 2: chatter on key 0 never qualifies
    saw_en = 1'b0; saw_pulse = 1'b0;
    for (int c = 0; c < 20; c++) begin
      kif.key_raw = (c % 4 < 2) ? 4'b1110 : 4'b1111;
      tick();
    end
    kif.key_raw = 4'b1111;
    repeat (DB + 4) tick();
    chk("t2_no_en", {3'd0, saw_en}, 4'd0);
    chk("t2_no_pulse", {3'd0, saw_pulse}, 4'd0);

    // 3: key 1 held, then key 3 added
    kif.key_raw = 4'b1101;
    wait_en(1'b1, n);
    chk("t3_onehot", kif.onehot, 4'b0010);
    kif.key_raw = 4'b0101;
    wait_err(1'b1, n);
    chk("t3_err_latency", 4'(n), 4'd7);
    chk("t3_err_onehot", kif.onehot, 4'd0);
    kif.key_raw = 4'b1111;
    wait_err(1'b0, n);
    chk("t3_err_clear", 4'(n), 4'd7);
    settle();

    // 4: two keys debounce on the same cycle
    saw_en = 1'b0;
    kif.key_raw = 4'b1100;
    wait_err(1'b1, n);
    chk("t4_err_latency", 4'(n), 4'd7);
    repeat (5) tick();
    chk("t4_never_en", {3'd0, saw_en}, 4'd0);
    settle();

    // 5: async reset mid-hold, held key re-debounces
    kif.key_raw = 4'b0111;
    wait_en(1'b1, n);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_onehot", kif.onehot, 4'd0);
    chk("t5_async_en", {3'd0, kif.en}, 4'd0);
    model_reset();
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    wait_en(1'b1, n);
    chk("t5_relatch", 4'(n), 4'd7);
    chk("t5_onehot", kif.onehot, 4'b1000);
    settle();

    // 6: press/release key 2, then key 0
    kif.key_raw = 4'b1011;
    wait_en(1'b1, n);
    kif.key_raw = 4'b1111;
    wait_en(1'b0, n);
    chk("t6_release", 4'(n), 4'd7);
    kif.key_raw = 4'b1110;
    wait_en(1'b1, n);
    chk("t6_onehot", kif.onehot, 4'b0001);
    settle();

    // random segments: clean single presses, multi-presses, chatter
    for (int s = 0; s < 70; s++) begin
      int kind, dur;
      logic [3:0] v;
      kind = $urandom_range(0, 3);
      dur  = $urandom_range(1, 12);
      case (kind)
        0: v = 4'b1111;
        1: v = ~(4'b0001 << $urandom_range(0, 3));
        2: v = 4'($urandom_range(0, 15));
        default: v = 4'b1111;
      endcase
      for (int c = 0; c < dur; c++) begin
        kif.key_raw = (kind == 3) ? 4'($urandom_range(0, 15)) : v;
        tick();
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
